// File: rtl/ps2_mouse_device.sv
// ps2_mouse_device: device-side PS/2 mouse that streams movement packets and answers host commands.
// Define PS2_DEV_RESEND_EN to make host byte FE retransmit the last byte sent instead of acknowledging it.
module ps2_mouse_device #(
  parameter int HALF_PERIOD = 4000,
  parameter int INHIBIT_MIN = 10000,
  parameter int GAP_CYCLES  = 8000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_mouse_i,
  output logic       clk_mouse_drive_low_o,
  input  logic       data_mouse_i,
  output logic       data_mouse_drive_low_o,
  input  logic       move_valid_i,
  output logic       move_ready_o,
  input  logic [2:0] move_buttons_i,
  input  logic [8:0] move_dx_i,
  input  logic [8:0] move_dy_i,
  output logic       stream_en_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_byte_o,
  output logic       cmd_parity_err_o
);
  localparam int CW = $clog2(HALF_PERIOD + INHIBIT_MIN + GAP_CYCLES + 1);
  localparam logic [CW-1:0] HP_END  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] HP_MID  = CW'(HALF_PERIOD / 2);
  localparam logic [CW-1:0] INH     = CW'(INHIBIT_MIN);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, TX_BIT, TX_GAP, INHIBIT, RX_BIT, RX_ACK, RESPOND} state_e;
  state_e state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic low_q, low_d;
  logic drv_clk_q, drv_clk_d, drv_dat_q, drv_dat_d;
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [2:0] len_q, len_d;
  logic [1:0] idx_q, idx_d;
  logic [9:0] rx_q, rx_d;
  logic stream_q, stream_d, err_q, err_d;
  logic [7:0] cmd_q, cmd_d;
`ifdef PS2_DEV_RESEND_EN
  logic [7:0] last_q, last_d;
`endif
  logic clk_s, dat_s, ph_end;
  logic [7:0] cur;
  logic [10:0] frame;
  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign ph_end = cnt_q == HP_END;
  assign cur = fifo_q[idx_q];
  assign frame = {1'b1, ~^cur, cur, 1'b0};
  assign move_ready_o = state_q == IDLE && stream_q && len_q == '0 && clk_s;
  assign clk_mouse_drive_low_o = drv_clk_q;
  assign data_mouse_drive_low_o = drv_dat_q;
  assign stream_en_o = stream_q;
  assign cmd_valid_o = state_q == RESPOND;
  assign cmd_byte_o = cmd_q;
  assign cmd_parity_err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      low_q <= 1'b0;
      drv_clk_q <= 1'b0;
      drv_dat_q <= 1'b0;
      fifo_q <= '{default: '0};
      len_q <= '0;
      idx_q <= '0;
      rx_q <= '0;
      stream_q <= 1'b0;
      err_q <= 1'b0;
      cmd_q <= '0;
`ifdef PS2_DEV_RESEND_EN
      last_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      clk_sync_q <= {clk_sync_q[0], clk_mouse_i};
      dat_sync_q <= {dat_sync_q[0], data_mouse_i};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      low_q <= low_d;
      drv_clk_q <= drv_clk_d;
      drv_dat_q <= drv_dat_d;
      fifo_q <= fifo_d;
      len_q <= len_d;
      idx_q <= idx_d;
      rx_q <= rx_d;
      stream_q <= stream_d;
      err_q <= err_d;
      cmd_q <= cmd_d;
`ifdef PS2_DEV_RESEND_EN
      last_q <= last_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = ph_end ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    low_d = low_q;
    drv_clk_d = drv_clk_q;
    drv_dat_d = drv_dat_q;
    fifo_d = fifo_q;
    len_d = len_q;
    idx_d = idx_q;
    rx_d = rx_q;
    stream_d = stream_q;
    err_d = err_q;
    cmd_d = cmd_q;
`ifdef PS2_DEV_RESEND_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        low_d = 1'b0;
        if (!clk_s) state_d = INHIBIT;
        else if (move_valid_i && move_ready_o) begin
          fifo_d[0] = {2'b00, move_dy_i[8], move_dx_i[8], 1'b1, move_buttons_i};
          fifo_d[1] = move_dx_i[7:0];
          fifo_d[2] = move_dy_i[7:0];
          len_d = 3'd3;
          idx_d = '0;
        end else if (len_q != '0) state_d = TX_BIT;
      end
      TX_BIT: begin
        // host inhibit before the parity bit rewinds to the first byte of the queued packet
        if (!low_q && cnt_q == HP_MID && !clk_s && bit_q < 4'd9) begin
          state_d = INHIBIT;
          cnt_d = '0;
          drv_dat_d = 1'b0;
          idx_d = '0;
        end else if (!low_q) begin
          if (cnt_q == HP_MID) drv_dat_d = ~frame[bit_q];
          if (ph_end) begin
            low_d = 1'b1;
            drv_clk_d = 1'b1;
          end
        end else if (ph_end) begin
          low_d = 1'b0;
          drv_clk_d = 1'b0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'd10) begin
            state_d = TX_GAP;
            bit_d = '0;
            idx_d = idx_q + 1'b1;
`ifdef PS2_DEV_RESEND_EN
            last_d = cur;
`endif
            if ({1'b0, idx_q} + 3'd1 == len_q) begin
              len_d = '0;
              idx_d = '0;
            end
          end
        end
      end
      TX_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_END) state_d = IDLE;
      end
      INHIBIT: begin
        if (!clk_s) cnt_d = (cnt_q >= INH) ? cnt_q : cnt_q + 1'b1;
        else if (cnt_q >= INH && !dat_s) begin
          state_d = RX_BIT;
          cnt_d = '0;
          bit_d = '0;
          low_d = 1'b1;
          drv_clk_d = 1'b1;
        end else state_d = IDLE;
      end
      RX_BIT: begin
        if (low_q) begin
          if (ph_end) begin
            low_d = 1'b0;
            drv_clk_d = 1'b0;
          end
        end else begin
          if (cnt_q == HP_MID) rx_d = {dat_s, rx_q[9:1]};
          if (ph_end) begin
            low_d = 1'b1;
            bit_d = bit_q + 1'b1;
            if (bit_q != 4'd9) drv_clk_d = 1'b1;
            else if (rx_q[9]) begin
              state_d = RX_ACK;
              drv_clk_d = 1'b1;
              drv_dat_d = 1'b1;
            end else state_d = IDLE;
          end
        end
      end
      RX_ACK: begin
        if (ph_end) begin
          low_d = 1'b0;
          drv_clk_d = 1'b0;
          if (!low_q) begin
            state_d = RESPOND;
            drv_dat_d = 1'b0;
            cmd_d = rx_q[7:0];
            err_d = ~^rx_q[8:0];
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
        len_d = 3'd1;
        idx_d = '0;
        fifo_d[0] = err_q ? 8'hFE : 8'hFA;
        if (!err_q) begin
          case (cmd_q)
            8'hFF: begin
              fifo_d[1] = 8'hAA;
              fifo_d[2] = 8'h00;
              len_d = 3'd3;
              stream_d = 1'b0;
            end
            8'hF4: stream_d = 1'b1;
            8'hF5: stream_d = 1'b0;
            8'hF2: begin
              fifo_d[1] = 8'h00;
              len_d = 3'd2;
            end
`ifdef PS2_DEV_RESEND_EN
            8'hFE: fifo_d[0] = last_q;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/ps2_mouse_device.md
Name: ps2_mouse_device

Overview:
- Synthesizable PS/2 mouse (device-side) model: owns the PS/2 clock, streams 3-byte movement packets, and accepts host commands with the device ACK bit.
- Pairs with our host-side mouse transceiver on the same board or in a loop-back bench; drives both lines open-drain.
- Used for self-test and mouse emulation from a movement source (e.g. buttons/joystick logic).

Parameters:
- HALF_PERIOD, 4000, CLK cycles per PS/2 clock half-period (12.5 kHz at 100 MHz).
- INHIBIT_MIN, 10000, CLK cycles host must hold CLK low to count as request-to-send (100 us).
- GAP_CYCLES, 8000, idle cycles between transmitted bytes.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- CLK_MOUSE_IN  in  1  sampled PS/2 clock line (already synchronised by 2 flops internally).
- CLK_MOUSE_DRIVE_LOW  out  1  1 = pull PS/2 clock low, 0 = release.
- DATA_MOUSE_IN  in  1  sampled PS/2 data line (2-flop synced internally).
- DATA_MOUSE_DRIVE_LOW  out  1  1 = pull data low, 0 = release.
- MOVE_VALID  in  1  movement packet offered.
- MOVE_READY  out  1  packet accepted when VALID & READY.
- MOVE_BUTTONS  in  3  {middle,right,left}.
- MOVE_DX  in  9  signed dx.
- MOVE_DY  in  9  signed dy.
- STREAM_EN  out  1  data reporting enabled.
- CMD_VALID  out  1  one-cycle pulse, host byte received.
- CMD_BYTE  out  8  last host byte.
- CMD_PARITY_ERR  out  1  qualifies CMD_VALID.

Behaviour:
- Reset (async, RESET=0): both DRIVE_LOW=0, STREAM_EN=0, MOVE_READY=0, CMD_VALID=0, CMD_BYTE=0, CMD_PARITY_ERR=0, queue empty, FSM=IDLE. Releasing reset mid-frame restarts cleanly; no partial frame is resumed.
- Response queue: 4-byte FIFO of bytes to transmit. Movement packet occupies 3 entries.
- MOVE_READY=1 only in IDLE, STREAM_EN=1, queue empty, host not inhibiting.
- Status byte: {ovfY,ovfX,DY[8],DX[8],1,BTN[2:0]}; ovf bits always 0. Then DX[7:0], DY[7:0].
- Device->host frame: 11 bits LSB-first: start 0, D0..D7, odd parity, stop 1. Per bit: data set at HALF_PERIOD/2 into CLK high, then CLK low HALF_PERIOD, high HALF_PERIOD. Host samples on falling edge.
- After each byte: GAP_CYCLES idle, then next queued byte.
- Inhibit during TX: CLK_MOUSE_IN low while device releases CLK (checked each high phase).
  - Before parity bit sent: abort, release lines, whole current packet/response stays queued and restarts from its first byte.
  - At/after parity: finish byte normally.
- FSM: IDLE -> TX_BIT -> TX_GAP -> IDLE; IDLE -> INHIBIT (CLK low seen) -> wait release.
  - CLK low >= INHIBIT_MIN and DATA low at release -> RX_BIT; else -> IDLE.
- RX_BIT: device generates 10 clocks, samples DATA at mid high phase: D0..D7, parity, stop.
- RX_ACK: 11th clock, device drives DATA low during it, then releases.
  - If stop=0: no ACK, byte discarded, no CMD_VALID.
- RESPOND: CMD_VALID pulse. Queue is flushed first, then responses are enqueued:
  - Parity error: FE.
  - FF: FA, AA, 00; STREAM_EN=0.
  - F4: FA; STREAM_EN=1.
  - F5: FA; STREAM_EN=0.
  - F2: FA, 00.
  - Any other: FA.
- Simultaneous MOVE_VALID and inhibit in the same cycle: inhibit wins, MOVE_READY=0.

Optional Feature:
- Macro PS2_DEV_RESEND_EN.
- Defined: last transmitted byte is held in a register; host byte FE re-enqueues that byte (queue flushed first); no FA is sent.
- Undefined: FE treated as an unknown command -> FA.

Test Plan:
- Reset, then host sends FF -> ACK bit low on 11th clock, CMD_VALID with CMD_BYTE=FF, device transmits FA, AA, 00 with correct odd parity.
- Host sends F4, then MOVE_VALID with BTN=001, DX=+5, DY=-3 -> bytes 0x29, 0x05, 0xFD; STREAM_EN=1.
- Host sends 0x55 with parity flipped -> CMD_PARITY_ERR=1, response FE.
- Host pulls CLK low 100 us during bit 4 of DX byte -> transmission aborts; after release the full packet 0x29, 0x05, 0xFD is resent.
- Host CLK low only 50 us with DATA low at release -> no RX, FSM returns IDLE, no CMD_VALID.
- With PS2_DEV_RESEND_EN defined: after AA, host sends FE -> device retransmits 00 (last byte); without the macro -> FA.
